dmem_responder: RTL and testbench

//   Slave-side data memory for the pipelined core: accepts one load/store

---
 rtl/dmem_responder.sv | 114 +++++++++++
 tb/tb_dmem_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data memory slave: one request at a time over valid/ready, a programmable number of
// wait states, then a byte-strobed access to a word array and a held response.
module dmem_responder #(
    parameter int unsigned N       = 32,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_we,
    input  logic [N-1:0]   req_addr,
    input  logic [N-1:0]   req_wdata,
    input  logic [N/8-1:0] req_wstrb,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic [N-1:0]   resp_rdata,
    output logic           resp_err
);

    localparam int unsigned NB = N / 8;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          lat_we;
    logic [N-1:0]  lat_addr;
    logic [N-1:0]  lat_wdata;
    logic [NB-1:0] lat_wstrb;

    logic [N-1:0]  mem [DEPTH];

    logic [N-3:0]  word_idx;
    logic [AW-1:0] mem_idx;
    logic          addr_err;

    always_comb begin
        word_idx = lat_addr[N-1:2];
        mem_idx  = word_idx[AW-1:0];
        addr_err = (lat_addr[1:0] != 2'b00) || ({2'b00, word_idx} >= N'(DEPTH));
    end

    // Array has no reset; a reset on the ACCESS edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && state == ACCESS && lat_we && !addr_err) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (lat_wstrb[i]) begin
                    mem[mem_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_wstrb  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_wstrb <= req_wstrb;
                        req_ready <= 1'b0;
                        if (LATENCY == 0) begin
                            state <= ACCESS;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= ACCESS;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACCESS: begin
                    resp_err   <= addr_err;
                    resp_rdata <= (addr_err || lat_we) ? '0 : mem[mem_idx];
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table, reset/stall corner cases, and randomized
// traffic against a word-array model, with LATENCY=2 and LATENCY=0 instances.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_ready, a_resp_err;
    logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic [3:0]  a_req_wstrb;
    logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready, b_resp_err;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
    logic [3:0]  b_req_wstrb;

    dmem_responder #(.N(32), .DEPTH(256), .LATENCY(2)) u_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wstrb(a_req_wstrb),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
    );

    dmem_responder #(.N(32), .DEPTH(256), .LATENCY(0)) u_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [256];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: error if misaligned or beyond the array, stores merge enabled bytes.
    task automatic model_apply(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, output logic [31:0] rdata, output logic err);
        int idx;
        idx   = int'(addr / 4);
        err   = (addr % 4 != 0) || (addr / 4 >= 256);
        rdata = 32'h0;
        if (!err) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                rdata = model_mem[idx];
            end
        end
    endtask

    task automatic scramble_a();
        a_req_valid = 1'($urandom_range(0, 1));
        a_req_we    = 1'($urandom_range(0, 1));
        a_req_addr  = $urandom;
        a_req_wdata = $urandom;
        a_req_wstrb = 4'($urandom_range(0, 15));
    endtask

    task automatic a_xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int hold,
                          input logic [31:0] exp_rdata, input logic exp_err, input string tag);
        int n;
        n = 0;
        while (!a_req_ready && n < 20) begin tick(); n++; end
        check({tag, "/ready_before"}, 32'(a_req_ready), 32'd1);
        a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr;
        a_req_wdata = wdata; a_req_wstrb = wstrb;
        tick();
        n = 0;
        while (!a_resp_valid && n < 20) begin
            check({tag, "/busy_ready"}, 32'(a_req_ready), 32'd0);
            scramble_a();
            tick();
            n++;
        end
        check({tag, "/latency"}, 32'(n), 32'd3);
        check({tag, "/rdata"}, a_resp_rdata, exp_rdata);
        check({tag, "/err"}, 32'(a_resp_err), 32'(exp_err));
        for (int h = 0; h < hold; h++) begin
            scramble_a();
            tick();
            check({tag, "/hold_valid"}, 32'(a_resp_valid), 32'd1);
            check({tag, "/hold_rdata"}, a_resp_rdata, exp_rdata);
            check({tag, "/hold_ready"}, 32'(a_req_ready), 32'd0);
        end
        a_req_valid  = 1'b0;
        a_resp_ready = 1'b1;
        tick();
        a_resp_ready = 1'b0;
        check({tag, "/done_valid"}, 32'(a_resp_valid), 32'd0);
        check({tag, "/done_ready"}, 32'(a_req_ready), 32'd1);
    endtask

    task automatic b_xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input string tag);
        b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr;
        b_req_wdata = wdata; b_req_wstrb = 4'hF;
        tick();
        b_req_valid = 1'b1; b_req_we = ~we; b_req_addr = $urandom;
        b_req_wdata = $urandom; b_req_wstrb = 4'($urandom_range(0, 15));
        check({tag, "/access_valid"}, 32'(b_resp_valid), 32'd0);
        check({tag, "/access_ready"}, 32'(b_req_ready), 32'd0);
        tick();
        check({tag, "/latency1_valid"}, 32'(b_resp_valid), 32'd1);
        check({tag, "/rdata"}, b_resp_rdata, exp_rdata);
        check({tag, "/err"}, 32'(b_resp_err), 32'd0);
        b_req_addr = $urandom;
        tick();
        check({tag, "/hold_rdata"}, b_resp_rdata, exp_rdata);
        b_req_valid  = 1'b0;
        b_resp_ready = 1'b1;
        tick();
        b_resp_ready = 1'b0;
        check({tag, "/done_ready"}, 32'(b_req_ready), 32'd1);
        check({tag, "/done_valid"}, 32'(b_resp_valid), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] er;
        logic        ee;
        logic [31:0] ad;
        int          n;

        vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h10,       32'h000000AA, 4'h1, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'h10,       32'h0,        4'hF, 32'hDEADBEAA, 1'b0};
        vecs[4]  = '{1'b0, 32'h13,       32'h0,        4'h0, 32'h0,        1'b1};
        vecs[5]  = '{1'b1, 32'h400,      32'h11223344, 4'hF, 32'h0,        1'b1};
        vecs[6]  = '{1'b1, 32'h12,       32'h55555555, 4'hF, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
        vecs[8]  = '{1'b1, 32'h14,       32'h12345678, 4'hF, 32'h0,        1'b0};
        vecs[9]  = '{1'b1, 32'h14,       32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
        vecs[10] = '{1'b1, 32'h14,       32'hAABBCCDD, 4'hA, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 32'h14,       32'h0,        4'h0, 32'hAA34CC78, 1'b0};
        vecs[12] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 32'h0,        1'b1};

        rst = 1'b1;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_wstrb = '0;
        a_resp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_wstrb = '0;
        b_resp_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("reset/a_req_ready", 32'(a_req_ready), 32'd1);
        check("reset/a_resp_valid", 32'(a_resp_valid), 32'd0);
        check("reset/a_resp_rdata", a_resp_rdata, 32'h0);
        check("reset/a_resp_err", 32'(a_resp_err), 32'd0);
        check("reset/b_req_ready", 32'(b_req_ready), 32'd1);
        check("reset/b_resp_valid", 32'(b_resp_valid), 32'd0);

        for (int i = 0; i < 13; i++) begin
            model_apply(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, er, ee);
            a_xact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 0,
                   vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Stalled response: held for five cycles with the requester not ready.
        a_xact(1'b0, 32'h10, 32'h0, 4'h0, 5, 32'hDEADBEAA, 1'b0, "stall5");

        for (int w = 0; w < 16; w++) begin
            ad = 32'(w * 4);
            n  = int'($urandom);
            model_apply(1'b1, ad, 32'(n), 4'hF, er, ee);
            a_xact(1'b1, ad, 32'(n), 4'hF, 0, 32'h0, 1'b0, "init");
        end

        // Reset while the store to 0x20 is still waiting: it must never land.
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h20;
        a_req_wdata = 32'h0BADF00D; a_req_wstrb = 4'hF;
        tick();
        a_req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_wait/req_ready", 32'(a_req_ready), 32'd1);
        check("rst_wait/resp_valid", 32'(a_resp_valid), 32'd0);
        check("rst_wait/rdata", a_resp_rdata, 32'h0);
        check("rst_wait/err", 32'(a_resp_err), 32'd0);
        a_xact(1'b0, 32'h20, 32'h0, 4'h0, 0, model_mem[8], 1'b0, "rst_wait_reload");

        // Reset with a response pending: it is dropped.
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h24;
        tick();
        a_req_valid = 1'b0;
        n = 0;
        while (!a_resp_valid && n < 20) begin tick(); n++; end
        check("rst_resp/latency", 32'(n), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_resp/resp_valid", 32'(a_resp_valid), 32'd0);
        check("rst_resp/req_ready", 32'(a_req_ready), 32'd1);
        check("rst_resp/rdata", a_resp_rdata, 32'h0);

        for (int t = 0; t < 60; t++) begin
            logic        we;
            logic [31:0] wd;
            logic [3:0]  ws;
            int          r;
            int          idx;
            r   = int'($urandom_range(0, 9));
            idx = int'($urandom_range(0, 15));
            if (r == 0)      ad = 32'(idx * 4 + int'($urandom_range(1, 3)));
            else if (r == 1) ad = 32'h400 + 32'(4 * $urandom_range(0, 1000));
            else             ad = 32'(idx * 4);
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            ws = 4'($urandom_range(0, 15));
            model_apply(we, ad, wd, ws, er, ee);
            a_xact(we, ad, wd, ws, int'($urandom_range(0, 3)), er, ee, $sformatf("rand%0d", t));
        end

        b_xact(1'b1, 32'h8, 32'hCAFEF00D, 32'h0, "lat0_store");
        b_xact(1'b0, 32'h8, 32'h0, 32'hCAFEF00D, "lat0_load");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
